// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a valid/ready input handshake.
// Line format: idle-high, start bit 0, DATA_BITS data bits LSB first, optional
// parity bit (even/odd/mark), one or two stop bits. The baud divisor, parity mode
// and stop-bit count are sampled when a word is accepted. The whole frame is then
// sent with those settings, whatever the inputs do later.
// Optional feature: define UART_TX_BREAK_EN to add the break_req input. It lets the
// line be held low while idle. A guard period of one bit time follows the release.
module uart_tx_param #(
  parameter int DATA_BITS = 8,   // legal range 5..9
  parameter int CLK_DIV_W = 16   // width of the runtime baud divisor, at least 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 active,
  output logic                 done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd5;
  localparam logic [2:0] S_GUARD  = 3'd6;
`endif

  logic [2:0]           state_q, state_d;
  logic [CLK_DIV_W-1:0] div_q, div_d;       // cycles per bit latched for this frame
  logic [CLK_DIV_W-1:0] cnt_q, cnt_d;       // cycle position inside the current bit
  logic [IDX_W-1:0]     idx_q, idx_d;       // data bit being sent
  logic [DATA_BITS-1:0] shreg_q, shreg_d;   // data word, shifted right one bit per data bit
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_idx_q, stop_idx_d;  // 0 = first stop bit, 1 = second
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic [CLK_DIV_W-1:0] div_eff;
  logic                 bit_end;
  logic                 par_calc;

  // Effective divisor: 0 and 1 would give zero-length bits, so both are treated as 2.
  assign div_eff = (clk_div < CLK_DIV_W'(2)) ? CLK_DIV_W'(2) : clk_div;
  assign bit_end = (cnt_q == div_q - CLK_DIV_W'(1));

  // Parity bit of the word presented for acceptance.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    par_calc = 1'b1;
    case (parity_mode)
      2'b01:   par_calc = ^tx_data;
      2'b10:   par_calc = ~^tx_data;
      default: par_calc = 1'b1;
    endcase
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    serial_d   = serial_q;
    ready_d    = ready_q;
    active_d   = active_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        ready_d  = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_d  = S_BREAK;
          div_d    = div_eff;
          cnt_d    = '0;
          serial_d = 1'b0;
          active_d = 1'b1;
          ready_d  = 1'b0;
        end else
`endif
        if (tx_valid && ready_q) begin
          state_d   = S_START;
          div_d     = div_eff;
          cnt_d     = '0;
          shreg_d   = tx_data;
          par_en_d  = |parity_mode;
          par_bit_d = par_calc;
          stop2_d   = stop2;
          serial_d  = 1'b0;
          active_d  = 1'b1;
          ready_d   = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d  = S_DATA;
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d  = S_PARITY;
              serial_d = par_bit_q;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              serial_d   = 1'b1;
            end
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            shreg_d  = shreg_q >> 1;
            serial_d = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          cnt_d      = '0;
          stop_idx_d = 1'b0;
          serial_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end

      S_STOP: begin
        serial_d = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            // End of frame: ready again on the same edge as the done pulse.
            state_d  = S_IDLE;
            done_d   = 1'b1;
            active_d = 1'b0;
            ready_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end

`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!break_req) begin
          state_d  = S_GUARD;
          cnt_d    = '0;
          serial_d = 1'b1;
        end
      end

      S_GUARD: begin
        if (bit_end) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          active_d = 1'b0;
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end
`endif

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        serial_d = 1'b1;
        active_d = 1'b0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State registers. Reset aborts any frame and drives the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from the values they held before the edge.
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      serial_q   <= 1'b1;
      ready_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      serial_q   <= serial_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready   = ready_q;
  assign serial_out = serial_q;
  assign active     = active_q;
  assign done       = done_q;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the team's fixed 8N1 transmitter. It adds configurable data width, a runtime baud divisor, runtime parity and stop-bit selection, and a valid/ready input handshake. It sits between a byte-stream producer (CPU bridge or FIFO) and the board TX pin. Line format: LSB-first, idle-high, start bit 0.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLK_DIV_W, 16, width of the runtime baud divisor input.

Ports:
clk  input  1  system clock.
rst  input  1  reset; asynchronous, active-high.
clk_div  input  CLK_DIV_W  clock cycles per bit (D); sampled at frame accept; values 0 and 1 are treated as 2.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 mark (constant 1); sampled at accept.
stop2  input  1  0 = one stop bit, 1 = two stop bits; sampled at accept.
tx_valid  input  1  producer has a word on tx_data.
tx_data  input  DATA_BITS  word to send.
tx_ready  output  1  transmitter can accept a word this cycle.
serial_out  output  1  serial line (registered).
active  output  1  high while a frame is on the line.
done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async, immediate): serial_out=1, tx_ready=0, active=0, done=0, state=IDLE, counters=0. tx_ready rises on the first clk edge after rst deasserts.
- Reset mid-frame: the frame is aborted, the line goes high at once, and no done pulse is produced.
- States: IDLE -> START -> DATA -> PARITY (skipped when parity_mode=00) -> STOP -> IDLE.
- Handshake: accept when tx_valid && tx_ready at a clk edge. tx_ready=1 only in IDLE; it is a registered output.
- At the accept edge: latch tx_data, D=max(clk_div,2), parity_mode and stop2; go to START; serial_out<=0; active<=1; tx_ready<=0. Later input changes have no effect on the frame in flight.
- Each bit lasts exactly D cycles. A bit counter of CLK_DIV_W bits counts 0..D-1.
- DATA: bit index 0..DATA_BITS-1, LSB first.
- PARITY bit value:
  - even = XOR of the data bits;
  - odd = inverse of that XOR;
  - mark = 1.
- STOP: serial_out=1 for D cycles, or 2*D cycles when stop2=1.
- End of the last stop period, on the same edge: state=IDLE, done=1 for one cycle, active=0, tx_ready=1, serial_out stays 1.
- Frame length = D*(1+DATA_BITS+P+S) cycles from the accept edge to the done edge, where P=0/1 and S=1/2.
- Back-to-back: if tx_valid is held, the next accept occurs one cycle after done. The minimum extra idle between frames is therefore 1 cycle.
- tx_valid while tx_ready=0 is ignored. The producer must hold tx_valid and tx_data until accepted.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input break_req (1 bit).
  - In IDLE, break_req has priority over tx_valid: serial_out<=0, active=1, tx_ready=0, for as long as it is held.
  - A request arriving mid-frame waits until IDLE.
  - On release: serial_out<=1, then a guard of D cycles (D latched when the break started), then return to IDLE with tx_ready=1.
  - No done pulse for a break.
- Undefined: no break_req port and no break logic; behaviour is exactly as above.

Test Plan:
- DATA_BITS=8, clk_div=4, parity 00, stop2=0, send 0xA5 -> line bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; done at cycle 40 after accept; tx_ready low for 40 cycles.
- clk_div=3, parity 01 with 0x07 -> parity bit 1. Parity 10 with 0x03 -> parity bit 1. Parity 11 with 0x00 -> parity bit 1. Each frame 33 cycles.
- clk_div=2, stop2=1, tx_valid held with 0x55 then 0xFF -> two frames of 22 cycles each, separated by exactly 1 idle-high cycle; two done pulses.
- clk_div=0 and clk_div=1 -> each bit lasts 2 cycles; 8N1 frame = 20 cycles.
- Assert rst during data bit 3 -> serial_out=1 and active=0 immediately (before the next clk edge); no done pulse; tx_ready=1 one edge after release; a new 0x3C frame then sends correctly.
- With UART_TX_BREAK_EN, clk_div=4: break_req held for 50 cycles -> serial_out=0 for 50 cycles, then 4 high guard cycles, then tx_ready=1; a tx_valid raised during the break is accepted only after the guard.
